// File: rtl/hilo_mdu_ctrl_if.sv
// HI/LO sequencer request/result bundle between the core pipeline and hilo_mdu_ctrl.
// Latency: none, wires only.
// Backpressure: the core must hold off new iterative requests while busy is high.
interface hilo_mdu_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_val, rt_val,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/hilo_mdu_ctrl.sv
// HI/LO sequencer: MTHI/MTLO in one edge, MULTU/DIVU over WIDTH shift iterations.
// Latency: MTHI/MTLO visible after the start edge; MULTU/DIVU commit with done after WIDTH+1 edges.
// Backpressure: none queued; start is dropped unless IDLE, the core stalls on busy.
module hilo_mdu_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic           clk,
    input  logic           arst,
    hilo_mdu_ctrl_if.slave bus
);

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;
    localparam logic [1:0] OP_MTHI  = 2'b10;
    localparam logic [1:0] OP_MTLO  = 2'b11;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_n;
    logic               is_div_q, is_div_n;
    logic [WIDTH-1:0]   opnd_q, opnd_n;   // multiplicand for MULTU, divisor for DIVU
    logic [WIDTH-1:0]   acc_q, acc_n;     // product high half / partial remainder
    logic [WIDTH-1:0]   sh_q, sh_n;       // multiplier shifting out / dividend shifting into quotient
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [WIDTH-1:0]   hi_q, hi_n;
    logic [WIDTH-1:0]   lo_q, lo_n;
    logic               busy_q, busy_n;
    logic               done_q, done_n;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_rem;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH-1:0]   iter_acc;
    logic [WIDTH-1:0]   iter_sh;

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q  <= IDLE;
            is_div_q <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            sh_q     <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            is_div_q <= is_div_n;
            opnd_q   <= opnd_n;
            acc_q    <= acc_n;
            sh_q     <= sh_n;
            cnt_q    <= cnt_n;
            hi_q     <= hi_n;
            lo_q     <= lo_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
        end
    end

    // One iteration of either algorithm; both leave the high half in acc and the low half in sh,
    // so commit is the same wiring for MULTU and DIVU.
    always_comb begin
        mul_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opnd_q} : '0);
        div_rem   = {acc_q, sh_q[WIDTH-1]};
        div_trial = div_rem - {1'b0, opnd_q};
        if (is_div_q) begin
            iter_acc = div_trial[WIDTH] ? div_rem[WIDTH-1:0] : div_trial[WIDTH-1:0];
            iter_sh  = {sh_q[WIDTH-2:0], ~div_trial[WIDTH]};
        end else begin
            iter_acc = mul_sum[WIDTH:1];
            iter_sh  = {mul_sum[0], sh_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_n  = state_q;
        is_div_n = is_div_q;
        opnd_n   = opnd_q;
        acc_n    = acc_q;
        sh_n     = sh_q;
        cnt_n    = cnt_q;
        hi_n     = hi_q;
        lo_n     = lo_q;
        busy_n   = 1'b0;
        done_n   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    unique case (bus.op)
                        OP_MTHI: hi_n = bus.rs_val;
                        OP_MTLO: lo_n = bus.rs_val;
                        OP_MULTU: begin
                            is_div_n = 1'b0;
                            opnd_n   = bus.rs_val;
                            sh_n     = bus.rt_val;
                            acc_n    = '0;
                            cnt_n    = '0;
                            busy_n   = 1'b1;
                            state_n  = RUN;
                        end
                        OP_DIVU: begin
                            is_div_n = 1'b1;
                            opnd_n   = bus.rt_val;
                            sh_n     = bus.rs_val;
                            acc_n    = '0;
                            cnt_n    = '0;
                            busy_n   = 1'b1;
                            state_n  = RUN;
                        end
                        default: ;
                    endcase
                end
            end
            RUN: begin
                acc_n = iter_acc;
                sh_n  = iter_sh;
                cnt_n = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    hi_n    = iter_acc;
                    lo_n    = iter_sh;
                    done_n  = 1'b1;
                    state_n = DONE;
                end else begin
                    busy_n  = 1'b1;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: doc/hilo_mdu_ctrl.md
Name: hilo_mdu_ctrl

Overview:
Sequencer for the HI/LO register pair of the MIPS core. It executes unsigned MULTU and DIVU over 32 shift iterations on an internal working datapath, then commits results to the architectural HI/LO registers. It also handles the single-cycle MTHI/MTLO writes. It sits beside the register file; the core stalls on busy and reads hi/lo for MFHI/MFLO.

Parameters:
WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.
CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  clock; all state changes on the rising edge.
arst  input  1  asynchronous active-low reset; 0 clears all state immediately.
start  input  1  request strobe; sampled only in IDLE.
op  input  2  operation: 00 MULTU, 01 DIVU, 10 MTHI, 11 MTLO.
rs_val  input  WIDTH  multiplicand / dividend / MTHI-MTLO source.
rt_val  input  WIDTH  multiplier / divisor; ignored for MTHI/MTLO.
busy  output  1  high while an iterative operation is in RUN.
done  output  1  one-cycle pulse in the DONE state.
hi  output  WIDTH  architectural HI register.
lo  output  WIDTH  architectural LO register.

Behaviour:
- Reset (arst=0, async): state=IDLE, count=0, working regs=0, hi=0, lo=0, busy=0, done=0. Reset mid-RUN abandons the operation; no partial result is committed.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE, start=1, op=MTHI: hi<=rs_val at that edge; stay IDLE; busy and done stay 0. MTLO is the same but writes lo.
- IDLE, start=1, op in {MULTU, DIVU}: at edge E0, latch op, a=rs_val, b=rt_val, clear acc, count=0, go to RUN. busy=1 from after E0.
- RUN: one iteration per edge E1..E32; count increments each edge. At E32 (count=WIDTH-1 before the edge): write hi/lo, go to DONE.
- MULTU, shift-add: if lsb of the multiplier shift register is 1, add a to acc with WIDTH+1-bit add. Then shift {carry, acc, mplier} right by 1. Final: hi=upper WIDTH bits, lo=lower WIDTH bits of the 2*WIDTH product.
- DIVU, restoring: shift {rem, quo} left by 1; trial = rem - b at WIDTH+1 bits. If trial is non-negative, rem=trial and quo lsb=1. Final: lo=quotient, hi=remainder.
- Divide by zero: no special case; the algorithm runs the full 32 iterations and yields lo=32'hFFFFFFFF, hi=dividend. No exception is raised.
- During RUN, hi/lo hold their pre-operation values; only the working registers change.
- DONE: busy=0, done=1 for exactly one cycle; next edge goes to IDLE. start is ignored in RUN and DONE; the request is dropped, not queued.
- Latency: start at E0 leads to hi/lo valid and done=1 in the cycle after E32 (33 edges). Minimum start-to-start spacing for iterative ops is 34 cycles.
- op is sampled only with start in IDLE; changing op or operands during RUN has no effect.

Test Plan:
- Reset check: arst=0 mid-cycle -> hi=0, lo=0, busy=0, done=0 immediately, without a clock edge.
- MTHI/MTLO: MTHI rs=32'hDEADBEEF, then MTLO rs=32'h12345678 on the next cycle -> hi=DEADBEEF, lo=12345678. busy never rises.
- MULTU: rs=32'hFFFFFFFF, rt=32'hFFFFFFFF -> after 33 edges done=1, hi=FFFFFFFE, lo=00000001. hi/lo keep old values during busy.
- DIVU: rs=100, rt=7 -> lo=14, hi=2. DIVU by zero with rs=32'h0000ABCD, rt=0 -> lo=FFFFFFFF, hi=0000ABCD.
- Start ignored while busy: pulse start with MTHI at E10 of a MULTU -> hi is not written by the MTHI and ends with only the MULTU result. done fires once.
- Reset mid-RUN: assert arst at E15 of a DIVU, release, then MULTU 3*5 -> after reset hi=lo=0. Final result is hi=0, lo=15.
